// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : shared LSU state encoding, access-width codes and helpers (rev 1.0)
// ============================================================================
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } lsu_state_t;

  localparam logic [3:0]  c_width_word      = 4'b0000;
  localparam logic [3:0]  c_width_half      = 4'b0101;
  localparam logic [3:0]  c_width_byte      = 4'b1010;
  localparam int unsigned c_timeout_default = 255;

  function automatic logic f_legal_width(input logic [3:0] width);
    return (width == c_width_word) || (width == c_width_half) || (width == c_width_byte);
  endfunction

  // Only meaningful for legal widths; bytes are always aligned.
  function automatic logic f_aligned(input logic [3:0] width, input logic [1:0] addr_lo);
    if (width == c_width_word) return (addr_lo == 2'b00);
    if (width == c_width_half) return !addr_lo[0];
    return 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_ctrl_if.sv
// ============================================================================
// lsu_ctrl_if : LSU memory-bus handshake bundle (rev 1.0)
// ============================================================================
`default_nettype none

interface lsu_ctrl_if;

  logic        bus_req_out;
  logic        bus_we_out;
  logic [31:0] bus_addr_out;
  logic [31:0] bus_wdata_out;
  logic [3:0]  bus_be_out;
  logic        bus_ack_in;
  logic        bus_err_in;
  logic [31:0] bus_rdata_in;

  modport master (
    output bus_req_out, bus_we_out, bus_addr_out, bus_wdata_out, bus_be_out,
    input  bus_ack_in, bus_err_in, bus_rdata_in
  );

  modport slave (
    input  bus_req_out, bus_we_out, bus_addr_out, bus_wdata_out, bus_be_out,
    output bus_ack_in, bus_err_in, bus_rdata_in
  );

endinterface

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// lsu_align : byte-lane enables, store replication and load extension (rev 1.0)
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [3:0]  i_width,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_zero_ext,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    if (i_width == c_width_byte) begin
      o_be    = 4'b0001 << i_addr_lo;
      o_wdata = {4{i_wdata[7:0]}};
      o_rdata = i_zero_ext ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
    end else if (i_width == c_width_half) begin
      o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
      o_wdata = {2{i_wdata[15:0]}};
      o_rdata = i_zero_ext ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
    end
  end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// lsu_ctrl : single-outstanding load/store bus sequencer with timeout (rev 1.0)
// ============================================================================
`default_nettype none

module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = c_timeout_default
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [3:0]  mem_width_in,
  input  logic        mem_zero_extend_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  lsu_ctrl_if.master  bus,
  output logic        busy_out,
  output logic        done_out,
  output logic [31:0] rdata_out,
  output logic        err_out
);

  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  r_state;
  lsu_state_t  w_next;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic        r_zext;
  logic [3:0]  r_width;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_bus_req;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic        w_one_kind;
  logic        w_req_ok;
  logic        w_req_bad;
  logic        w_expire;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  assign w_one_kind = mem_read_in ^ mem_write_in;
  assign w_req_ok   = start_in && w_one_kind && f_legal_width(mem_width_in)
                      && f_aligned(mem_width_in, addr_in[1:0]);
  // Neither read nor write set is a no-op, not a fault.
  assign w_req_bad  = start_in && ((mem_read_in && mem_write_in) ||
                      (w_one_kind && !(f_legal_width(mem_width_in)
                      && f_aligned(mem_width_in, addr_in[1:0]))));
  assign w_expire   = (r_cnt >= c_cnt_last);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req_ok)       w_next = ST_BUS;
        else if (w_req_bad) w_next = ST_ERR;
      end
      ST_BUS: begin
        if (bus.bus_err_in)      w_next = ST_ERR;
        else if (bus.bus_ack_in) w_next = ST_DONE;
        else if (w_expire)       w_next = ST_ERR;
      end
      ST_DONE: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bus_req <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_bus_req <= (w_next == ST_BUS);
      r_busy    <= (w_next != ST_IDLE);
      r_done    <= (w_next == ST_DONE);
      r_err     <= (w_next == ST_ERR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 8'h00;
      r_we    <= 1'b0;
      r_zext  <= 1'b0;
      r_width <= 4'h0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
    end else begin
      if (r_state == ST_IDLE && w_req_ok) begin
        r_cnt   <= 8'h00;
        r_we    <= mem_write_in;
        r_zext  <= mem_zero_extend_in;
        r_width <= mem_width_in;
        r_addr  <= addr_in;
        r_wdata <= wdata_in;
      end else if (r_state == ST_BUS && !bus.bus_ack_in && r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (r_state == ST_BUS && bus.bus_ack_in && !bus.bus_err_in && !r_we)
        r_rdata <= w_load_data;
    end
  end

  lsu_align u_align (
    .i_width    (r_width),
    .i_addr_lo  (r_addr[1:0]),
    .i_zero_ext (r_zext),
    .i_wdata    (r_wdata),
    .i_rdata    (bus.bus_rdata_in),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_load_data)
  );

  // Bus fields are gated so the bus is quiet outside the BUS state.
  assign bus.bus_req_out   = r_bus_req;
  assign bus.bus_we_out    = r_bus_req & r_we;
  assign bus.bus_addr_out  = r_bus_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign bus.bus_wdata_out = r_bus_req ? w_wdata : 32'h0;
  assign bus.bus_be_out    = r_bus_req ? w_be : 4'h0;

  assign busy_out  = r_busy;
  assign done_out  = r_done;
  assign err_out   = r_err;
  assign rdata_out = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// tb_lsu_ctrl : directed self-checking bench for lsu_ctrl (rev 1.0)
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [3:0]  mem_width_in;
  logic        mem_zero_extend_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        busy_out;
  logic        done_out;
  logic [31:0] rdata_out;
  logic        err_out;
  int          n_tests = 0;
  int          n_fail  = 0;

  lsu_ctrl_if bus_if ();

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_in           (start_in),
    .mem_read_in        (mem_read_in),
    .mem_write_in       (mem_write_in),
    .mem_width_in       (mem_width_in),
    .mem_zero_extend_in (mem_zero_extend_in),
    .addr_in            (addr_in),
    .wdata_in           (wdata_in),
    .bus                (bus_if),
    .busy_out           (busy_out),
    .done_out           (done_out),
    .rdata_out          (rdata_out),
    .err_out            (err_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for a single cycle; returns one cycle later.
  task automatic issue(input logic rd, input logic wr, input logic [3:0] w,
                       input logic zx, input logic [31:0] a, input logic [31:0] d);
    start_in = 1'b1; mem_read_in = rd; mem_write_in = wr; mem_width_in = w;
    mem_zero_extend_in = zx; addr_in = a; wdata_in = d;
    tick();
    start_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if ({busy_out, done_out, err_out, bus_if.bus_req_out, bus_if.bus_we_out} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b exp 00000",
        {busy_out, done_out, err_out, bus_if.bus_req_out, bus_if.bus_we_out});
    end
    n_tests++;
    if (rdata_out !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h exp 00000000", rdata_out); end
    n_tests++;
    if ({bus_if.bus_addr_out, bus_if.bus_wdata_out, bus_if.bus_be_out} !== 68'h0) begin
      n_fail++; $display("FAIL reset_bus: addr %h wdata %h be %b exp all 0",
        bus_if.bus_addr_out, bus_if.bus_wdata_out, bus_if.bus_be_out);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lb();
    issue(1'b1, 1'b0, c_width_byte, 1'b0, 32'h0000_0103, 32'h0);
    n_tests++;
    if (bus_if.bus_req_out !== 1'b1 || busy_out !== 1'b1) begin
      n_fail++; $display("FAIL lb_req: req %b busy %b exp 1 1", bus_if.bus_req_out, busy_out);
    end
    n_tests++;
    if (bus_if.bus_be_out !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b exp 1000", bus_if.bus_be_out); end
    n_tests++;
    if (bus_if.bus_addr_out !== 32'h100 || bus_if.bus_we_out !== 1'b0) begin
      n_fail++; $display("FAIL lb_addr: addr %h we %b exp 00000100 0", bus_if.bus_addr_out, bus_if.bus_we_out);
    end
    bus_if.bus_rdata_in = 32'h8012_3456; bus_if.bus_ack_in = 1'b1;
    tick();
    bus_if.bus_ack_in = 1'b0;
    n_tests++;
    if (done_out !== 1'b1 || bus_if.bus_req_out !== 1'b0) begin
      n_fail++; $display("FAIL lb_done: done %b req %b exp 1 0", done_out, bus_if.bus_req_out);
    end
    n_tests++;
    if (rdata_out !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h exp ffffff80", rdata_out); end
    tick();
    n_tests++;
    if (done_out !== 1'b0 || busy_out !== 1'b0) begin
      n_fail++; $display("FAIL lb_idle: done %b busy %b exp 0 0", done_out, busy_out);
    end
  endtask

  task automatic test_lhu();
    issue(1'b1, 1'b0, c_width_half, 1'b1, 32'h0000_0202, 32'h0);
    n_tests++;
    if (bus_if.bus_be_out !== 4'b1100 || bus_if.bus_addr_out !== 32'h200) begin
      n_fail++; $display("FAIL lhu_bus: be %b addr %h exp 1100 00000200", bus_if.bus_be_out, bus_if.bus_addr_out);
    end
    bus_if.bus_rdata_in = 32'h8001_ABCD; bus_if.bus_ack_in = 1'b1;
    tick();
    bus_if.bus_ack_in = 1'b0;
    n_tests++;
    if (rdata_out !== 32'h0000_8001 || done_out !== 1'b1) begin
      n_fail++; $display("FAIL lhu_rdata: got %h done %b exp 00008001 1", rdata_out, done_out);
    end
    tick();
  endtask

  task automatic test_sw_back_to_back_start();
    issue(1'b0, 1'b1, c_width_word, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    n_tests++;
    if (bus_if.bus_we_out !== 1'b1 || bus_if.bus_be_out !== 4'b1111) begin
      n_fail++; $display("FAIL sw_we_be: we %b be %b exp 1 1111", bus_if.bus_we_out, bus_if.bus_be_out);
    end
    n_tests++;
    if (bus_if.bus_wdata_out !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL sw_wdata: got %h exp deadbeef", bus_if.bus_wdata_out);
    end
    issue(1'b1, 1'b0, c_width_byte, 1'b0, 32'h0000_0003, 32'h0);
    n_tests++;
    if (bus_if.bus_addr_out !== 32'h10 || bus_if.bus_be_out !== 4'b1111 || bus_if.bus_we_out !== 1'b1) begin
      n_fail++; $display("FAIL sw_hold: addr %h be %b we %b exp 00000010 1111 1",
        bus_if.bus_addr_out, bus_if.bus_be_out, bus_if.bus_we_out);
    end
    tick();
    bus_if.bus_rdata_in = 32'h1111_1111; bus_if.bus_ack_in = 1'b1;
    n_tests++;
    if (done_out !== 1'b0) begin n_fail++; $display("FAIL sw_early_done: got %b exp 0", done_out); end
    tick();
    bus_if.bus_ack_in = 1'b0;
    n_tests++;
    if (done_out !== 1'b1 || rdata_out !== 32'h0000_8001) begin
      n_fail++; $display("FAIL sw_done: done %b rdata %h exp 1 00008001", done_out, rdata_out);
    end
    tick();
    n_tests++;
    if (busy_out !== 1'b0) begin n_fail++; $display("FAIL sw_idle: busy %b exp 0", busy_out); end
  endtask

  task automatic test_store_half();
    issue(1'b0, 1'b1, c_width_half, 1'b0, 32'h0000_0022, 32'h1234_BEEF);
    n_tests++;
    if (bus_if.bus_be_out !== 4'b1100 || bus_if.bus_wdata_out !== 32'hBEEF_BEEF || bus_if.bus_addr_out !== 32'h20) begin
      n_fail++; $display("FAIL sh_bus: be %b wdata %h addr %h exp 1100 beefbeef 00000020",
        bus_if.bus_be_out, bus_if.bus_wdata_out, bus_if.bus_addr_out);
    end
    bus_if.bus_ack_in = 1'b1;
    tick();
    bus_if.bus_ack_in = 1'b0;
    tick();
    issue(1'b0, 1'b1, c_width_byte, 1'b0, 32'h0000_0001, 32'h0000_00A5);
    n_tests++;
    if (bus_if.bus_be_out !== 4'b0010 || bus_if.bus_wdata_out !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL sb_bus: be %b wdata %h exp 0010 a5a5a5a5", bus_if.bus_be_out, bus_if.bus_wdata_out);
    end
    bus_if.bus_ack_in = 1'b1;
    tick();
    bus_if.bus_ack_in = 1'b0;
    tick();
  endtask

  task automatic test_err_wins();
    issue(1'b1, 1'b0, c_width_byte, 1'b1, 32'h0000_0001, 32'h0);
    bus_if.bus_rdata_in = 32'hFFFF_FFFF; bus_if.bus_ack_in = 1'b1; bus_if.bus_err_in = 1'b1;
    tick();
    bus_if.bus_ack_in = 1'b0; bus_if.bus_err_in = 1'b0;
    n_tests++;
    if (err_out !== 1'b1 || done_out !== 1'b0) begin
      n_fail++; $display("FAIL errwin_pulse: err %b done %b exp 1 0", err_out, done_out);
    end
    n_tests++;
    if (rdata_out !== 32'h0000_8001) begin n_fail++; $display("FAIL errwin_rdata: got %h exp 00008001", rdata_out); end
    tick();
    n_tests++;
    if (err_out !== 1'b0 || busy_out !== 1'b0) begin
      n_fail++; $display("FAIL errwin_idle: err %b busy %b exp 0 0", err_out, busy_out);
    end
  endtask

  task automatic test_misaligned();
    issue(1'b1, 1'b0, c_width_word, 1'b0, 32'h0000_0006, 32'h0);
    n_tests++;
    if (err_out !== 1'b1 || bus_if.bus_req_out !== 1'b0 || busy_out !== 1'b1) begin
      n_fail++; $display("FAIL lw_misalign: err %b req %b busy %b exp 1 0 1", err_out, bus_if.bus_req_out, busy_out);
    end
    tick();
    n_tests++;
    if (err_out !== 1'b0 || bus_if.bus_req_out !== 1'b0 || busy_out !== 1'b0) begin
      n_fail++; $display("FAIL lw_misalign_after: err %b req %b busy %b exp 0 0 0", err_out, bus_if.bus_req_out, busy_out);
    end
    issue(1'b1, 1'b0, c_width_half, 1'b0, 32'h0000_0003, 32'h0);
    n_tests++;
    if (err_out !== 1'b1 || bus_if.bus_req_out !== 1'b0) begin
      n_fail++; $display("FAIL lh_misalign: err %b req %b exp 1 0", err_out, bus_if.bus_req_out);
    end
    tick();
  endtask

  task automatic test_illegal();
    issue(1'b1, 1'b0, 4'b0011, 1'b0, 32'h0000_0000, 32'h0);
    n_tests++;
    if (err_out !== 1'b1) begin n_fail++; $display("FAIL bad_width: err %b exp 1", err_out); end
    tick();
    issue(1'b1, 1'b1, c_width_word, 1'b0, 32'h0000_0000, 32'h0);
    n_tests++;
    if (err_out !== 1'b1 || bus_if.bus_req_out !== 1'b0) begin
      n_fail++; $display("FAIL rd_and_wr: err %b req %b exp 1 0", err_out, bus_if.bus_req_out);
    end
    tick();
    issue(1'b0, 1'b0, 4'b0011, 1'b0, 32'h0000_0001, 32'h0);
    n_tests++;
    if ({busy_out, err_out, done_out, bus_if.bus_req_out} !== 4'b0000) begin
      n_fail++; $display("FAIL no_kind: busy/err/done/req %b exp 0000",
        {busy_out, err_out, done_out, bus_if.bus_req_out});
    end
  endtask

  task automatic test_timeout();
    issue(1'b1, 1'b0, c_width_word, 1'b0, 32'h0000_0020, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      n_tests++;
      if (bus_if.bus_req_out !== 1'b1 || err_out !== 1'b0) begin
        n_fail++; $display("FAIL timeout_wait%0d: req %b err %b exp 1 0", c, bus_if.bus_req_out, err_out);
      end
      tick();
    end
    n_tests++;
    if (err_out !== 1'b1 || bus_if.bus_req_out !== 1'b0) begin
      n_fail++; $display("FAIL timeout_err: err %b req %b exp 1 0", err_out, bus_if.bus_req_out);
    end
    tick();
    issue(1'b1, 1'b0, c_width_half, 1'b0, 32'h0000_0300, 32'h0);
    n_tests++;
    if (bus_if.bus_req_out !== 1'b1 || bus_if.bus_be_out !== 4'b0011) begin
      n_fail++; $display("FAIL timeout_next_req: req %b be %b exp 1 0011", bus_if.bus_req_out, bus_if.bus_be_out);
    end
    bus_if.bus_rdata_in = 32'h1234_F00F; bus_if.bus_ack_in = 1'b1;
    tick();
    bus_if.bus_ack_in = 1'b0;
    n_tests++;
    if (done_out !== 1'b1 || rdata_out !== 32'hFFFF_F00F) begin
      n_fail++; $display("FAIL timeout_next_load: done %b rdata %h exp 1 fffff00f", done_out, rdata_out);
    end
    tick();
  endtask

  task automatic test_ack_at_expiry();
    issue(1'b1, 1'b0, c_width_word, 1'b1, 32'h0000_0040, 32'h0);
    tick(); tick(); tick();
    bus_if.bus_rdata_in = 32'hCAFE_F00D; bus_if.bus_ack_in = 1'b1;
    tick();
    bus_if.bus_ack_in = 1'b0;
    n_tests++;
    if (done_out !== 1'b1 || err_out !== 1'b0 || rdata_out !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL ack_expiry: done %b err %b rdata %h exp 1 0 cafef00d", done_out, err_out, rdata_out);
    end
    tick();
  endtask

  task automatic test_reset_mid_bus();
    logic saw_pulse;
    saw_pulse = 1'b0;
    issue(1'b1, 1'b0, c_width_word, 1'b0, 32'h0000_0080, 32'h0);
    tick();
    bus_if.bus_rdata_in = 32'h5555_5555;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus_if.bus_req_out !== 1'b0 || busy_out !== 1'b0 || rdata_out !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_bus: req %b busy %b rdata %h exp 0 0 00000000",
        bus_if.bus_req_out, busy_out, rdata_out);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (done_out !== 1'b0 || err_out !== 1'b0 || bus_if.bus_req_out !== 1'b0) saw_pulse = 1'b1;
      tick();
    end
    n_tests++;
    if (saw_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_no_pulse: got %b exp 0", saw_pulse); end
  endtask

  initial begin
    rst_n = 1'b0; start_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    mem_width_in = 4'h0; mem_zero_extend_in = 1'b0; addr_in = 32'h0; wdata_in = 32'h0;
    bus_if.bus_ack_in = 1'b0; bus_if.bus_err_in = 1'b0; bus_if.bus_rdata_in = 32'h0;
    test_reset();
    test_lb();
    test_lhu();
    test_sw_back_to_back_start();
    test_store_half();
    test_err_wins();
    test_misaligned();
    test_illegal();
    test_timeout();
    test_ack_at_expiry();
    test_reset_mid_bus();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
